// File: rtl/tile_ram_writer_pkg.sv
// Shared opcodes, FSM state encoding and BCD digit step for the tile RAM writer.
package tile_ram_writer_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_INC   = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Returns {carry, next digit}; anything at or above 9 rolls over to 0.
  function automatic logic [4:0] bcd_step(input logic [3:0] nib);
    logic [4:0] res;
    if (nib >= BCD_MAX) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, nib + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/tile_ram_writer_bcd_digit_inc.sv
// Combinational single-digit BCD incrementer used on the INC capture path.
module bcd_digit_inc
  import tile_ram_writer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o,
  output logic       carry_o
);

  // Pure digit step, no state.
  always_comb begin
    {carry_o, nib_o} = bcd_step(nib_i);
  end

endmodule

// File: rtl/tile_ram_writer.sv
// Command-driven writer for the tile RAM: single writes, block fills and BCD increments.
// Optional build macro TILE_RAM_WRITER_OVF_EN adds a sticky ovf output for INC carry-out.
module tile_ram_writer
  import tile_ram_writer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_done,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we
`ifdef TILE_RAM_WRITER_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              carry_q, carry_d;
  logic [3:0]        nib_next_s;
  logic              nib_carry_s;
  logic              last_s;
`ifdef TILE_RAM_WRITER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  bcd_digit_inc u_digit_inc (
    .nib_i   (ram_dout[3:0]),
    .nib_o   (nib_next_s),
    .carry_o (nib_carry_s)
  );

  // A count of 0 means a full 2**ADDR_W pass, so "last" is tested as rem==1.
  assign last_s = (rem_q == ADDR_W'(1));

  // State and command registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= {ADDR_W{1'b0}};
      rem_q   <= {ADDR_W{1'b0}};
      din_q   <= {DATA_W{1'b0}};
      carry_q <= 1'b0;
`ifdef TILE_RAM_WRITER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      carry_q <= carry_d;
`ifdef TILE_RAM_WRITER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic; RAM-facing states hold whenever the port is not granted.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    din_d   = din_q;
    carry_d = carry_q;
`ifdef TILE_RAM_WRITER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          din_d  = cmd_data;
`ifdef TILE_RAM_WRITER_OVF_EN
          ovf_d  = 1'b0;
`endif
          case (cmd_op)
            OP_WRITE: state_d = ST_WR;
            OP_FILL:  state_d = ST_WR;
            OP_INC:   state_d = ST_RD;
            OP_NOP:   state_d = ST_DONE;
            default:  state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (bus_grant) begin
          state_d = ST_CAP;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_CAP: begin
        // Without the grant the read data may belong to the video side, so read again.
        if (bus_grant) begin
          din_d   = (ram_dout & ~DATA_W'(4'hF)) | DATA_W'(nib_next_s);
          carry_d = nib_carry_s;
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (bus_grant) begin
          case (op_q)
            OP_FILL: begin
              if (last_s) begin
                state_d = ST_DONE;
              end else begin
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                state_d = ST_WR;
              end
            end
            OP_INC: begin
              if (carry_q && !last_s) begin
                addr_d  = addr_q - ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                state_d = ST_RD;
              end else begin
`ifdef TILE_RAM_WRITER_OVF_EN
                ovf_d   = ovf_q | carry_q;
`endif
                state_d = ST_DONE;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_done  = (state_q == ST_DONE);
  assign ram_we    = (state_q == ST_WR) && bus_grant;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
`ifdef TILE_RAM_WRITER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_tile_ram_writer.sv
// Directed bench for tile_ram_writer: bench-side tile RAM, expected-write scoreboard and latency checks.
// Define TILE_RAM_WRITER_OVF_EN for both DUT and bench to cover the ovf output.
module tb_tile_ram_writer;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_done, bus_grant, ram_we;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr, cmd_len, ram_addr;
  logic [DW-1:0] cmd_data, ram_din, ram_dout;
`ifdef TILE_RAM_WRITER_OVF_EN
  logic          ovf;
`endif

  // Tile RAM as seen by the DUT, plus the bench's expectation of its contents.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  localparam logic [AW-1:0] VIDEO_ADDR = 10'd100;
  int cyc = 0;

  // Expected write stream: pushed by the stimulus, consumed by the compare process.
  logic [AW-1:0] exp_a [4096];
  logic [DW-1:0] exp_d [4096];
  logic [11:0]   wr_head, rd_tail;
  int            done_issued, done_seen;
  int            n_total, n_bad;
  string         req_name;
  logic [31:0]   req_act, req_exp;
  int            req_id, ack_id;

  tile_ram_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .cmd_done  (cmd_done),
    .bus_grant (bus_grant),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_we    (ram_we)
`ifdef TILE_RAM_WRITER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM behind the grant mux; the video side reads VIDEO_ADDR when not granted.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[bus_grant ? ram_addr : VIDEO_ADDR];
  end

  // Compare process: every negedge, check writes, done pulses and posted literal checks.
  initial begin : compare
    n_total = 0; n_bad = 0; rd_tail = 12'd0; done_seen = 0; ack_id = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_total++;
        if (ram_we !== 1'b0 || cmd_done !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_quiet: got we=%0b done=%0b want we=0 done=0", ram_we, cmd_done);
        end
        rd_tail   = wr_head;
        done_seen = done_issued;
      end else begin
        if (bd_we) ref_mem[bd_addr] = bd_data;
        if (ram_we) begin
          n_total++;
          if (!bus_grant) begin
            n_bad++;
            $display("FAIL we_grant: got write at %0h without grant, want no write", ram_addr);
          end else if (rd_tail == wr_head) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%0h din=%0h, want no write", ram_addr, ram_din);
          end else begin
            if (ram_addr !== exp_a[rd_tail] || ram_din !== exp_d[rd_tail]) begin
              n_bad++;
              $display("FAIL write: got addr=%0h din=%0h want addr=%0h din=%0h",
                       ram_addr, ram_din, exp_a[rd_tail], exp_d[rd_tail]);
            end
            ref_mem[exp_a[rd_tail]] = exp_d[rd_tail];
            rd_tail = rd_tail + 12'd1;
          end
        end
        if (cmd_done) begin
          n_total++;
          if (done_seen >= done_issued) begin
            n_bad++;
            $display("FAIL unexpected_done: got done pulse, want none (seen=%0d issued=%0d)",
                     done_seen, done_issued);
          end else begin
            if (rd_tail != wr_head) begin
              n_bad++;
              $display("FAIL done_early: got done with %0d writes pending, want 0",
                       wr_head - rd_tail);
            end
            done_seen++;
          end
        end
      end
      if (req_id != ack_id) begin
        n_total++;
        if (req_act !== req_exp) begin
          n_bad++;
          $display("FAIL %s: got %0h want %0h", req_name, req_act, req_exp);
        end
        ack_id = req_id;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    req_name = name;
    req_act  = act;
    req_exp  = exp;
    req_id++;
    @(negedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bd_we   = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_a[wr_head] = a;
    exp_d[wr_head] = d;
    wr_head = wr_head + 12'd1;
  endtask

  // Issue one command, predict its writes from ref_mem, and measure accept->done latency.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] len,
                         input logic [DW-1:0] d, input int budget, input bit garbage,
                         input bit cap_drop, output int lat, output bit carry_out);
    int            n, acc, off;
    logic [AW-1:0] p;
    logic [DW-1:0] v;
    logic [3:0]    nib;
    bit            c;
    n = (len == 0) ? DEPTH : int'(len);
    c = 1'b0;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    case (op)
      2'd0: push(a, d);
      2'd1: for (int i = 0; i < n; i++) push(a + AW'(i), d);
      2'd2: begin
        p = a;
        for (int i = 0; i < n; i++) begin
          v = ref_mem[p];
          if (v[3:0] >= 4'd9) begin nib = 4'd0; c = 1'b1; end
          else begin nib = v[3:0] + 4'd1; c = 1'b0; end
          push(p, {v[7:4], nib});
          if (!c) break;
          p = p - AW'(1);
        end
      end
      default: ;
    endcase
    carry_out = c;
    tick();
    acc = cyc;
    cmd_op = op; cmd_addr = a; cmd_len = len; cmd_data = d; cmd_valid = 1'b1;
    done_issued++;
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      off = cyc - acc;
      cmd_valid = garbage;
      if (garbage) begin cmd_op = 2'd0; cmd_addr = 10'h3FF; cmd_data = 8'hEE; end
      bus_grant = !(cap_drop && (off == 2 || off == 7 || off == 12));
      if (cmd_done) begin
        lat = off;
        cmd_valid = 1'b0;
        bus_grant = 1'b1;
        break;
      end
    end
  endtask

  initial begin : main
    int lat, nmis;
    bit co;
    logic s_we, s_rdy, s_done;
    wr_head = 12'd0; done_issued = 0; req_id = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 10'd0; cmd_len = 10'd0;
    cmd_data = 8'd0; bus_grant = 1'b1; bd_we = 1'b0; bd_addr = 10'd0; bd_data = 8'd0;

    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(cmd_done), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // len 0 means all 1024 cells, wrapping from 7 round to 6.
    run_cmd(2'd1, 10'd7, 10'd0, 8'h5A, 1100, 1'b0, 1'b0, lat, co);
    check("lat_fill_all", 32'(lat), 32'd1025);
    check("fill_all_cell6", 32'(mem[6]), 32'h5A);
    poke(10'd4, 8'h44);
    poke(VIDEO_ADDR, 8'h55);

    run_cmd(2'd0, 10'd5, 10'd0, 8'h37, 40, 1'b0, 1'b0, lat, co);
    check("lat_write", 32'(lat), 32'd2);
    check("write_cell5", 32'(mem[5]), 32'h37);

    // Wrapping fill with junk offered on cmd_* while busy.
    run_cmd(2'd1, 10'd1020, 10'd8, 8'h00, 40, 1'b1, 1'b0, lat, co);
    check("lat_fill8", 32'(lat), 32'd9);
    check("fill_cell3", 32'(mem[3]), 32'h00);
    check("fill_cell4_kept", 32'(mem[4]), 32'h44);

    poke(10'd29, 8'h01); poke(10'd30, 8'h09); poke(10'd31, 8'h09);
    run_cmd(2'd2, 10'd31, 10'd3, 8'h00, 40, 1'b0, 1'b0, lat, co);
    check("lat_inc3", 32'(lat), 32'd10);
    check("inc_cell29", 32'(mem[29]), 32'h02);
    check("inc_cell30", 32'(mem[30]), 32'h00);
    check("inc_cell31", 32'(mem[31]), 32'h00);

    // Same increment with the grant pulled in the first CAP cycle of each digit.
    poke(10'd29, 8'h01); poke(10'd30, 8'h09); poke(10'd31, 8'h09);
    run_cmd(2'd2, 10'd31, 10'd3, 8'h00, 60, 1'b0, 1'b1, lat, co);
    check("lat_inc3_capdrop", 32'(lat), 32'd16);
    check("capdrop_cell29", 32'(mem[29]), 32'h02);
    check("capdrop_cell30", 32'(mem[30]), 32'h00);
    check("capdrop_cell31", 32'(mem[31]), 32'h00);

    // Digit address wraps 0 -> 1023; upper nibble must survive.
    poke(10'd0, 8'hF9); poke(10'd1023, 8'h37);
    run_cmd(2'd2, 10'd0, 10'd2, 8'h00, 40, 1'b0, 1'b0, lat, co);
    check("lat_inc_wrap", 32'(lat), 32'd7);
    check("incwrap_cell0", 32'(mem[0]), 32'hF0);
    check("incwrap_cell1023", 32'(mem[1023]), 32'h38);

    poke(10'd50, 8'h13);
    run_cmd(2'd2, 10'd50, 10'd5, 8'h00, 40, 1'b0, 1'b0, lat, co);
    check("lat_inc_nocarry", 32'(lat), 32'd4);
    check("nocarry_cell50", 32'(mem[50]), 32'h14);

    poke(10'd200, 8'h09); poke(10'd201, 8'h09);
    run_cmd(2'd2, 10'd201, 10'd2, 8'h00, 40, 1'b0, 1'b0, lat, co);
    check("lat_inc_ovf", 32'(lat), 32'd7);
    check("model_carry_out", 32'(co), 32'd1);
    check("ovf_cell200", 32'(mem[200]), 32'h00);
    check("ovf_cell201", 32'(mem[201]), 32'h00);
`ifdef TILE_RAM_WRITER_OVF_EN
    tick();
    check("ovf_set", 32'(ovf), 32'd1);
`endif
    run_cmd(2'd3, 10'd0, 10'd0, 8'h00, 40, 1'b0, 1'b0, lat, co);
    check("lat_nop", 32'(lat), 32'd1);
`ifdef TILE_RAM_WRITER_OVF_EN
    check("ovf_cleared", 32'(ovf), 32'd0);
`endif

    // Reset in the middle of a fill: cells 300..303 written, 304 untouched.
    for (int i = 0; i < 16; i++) push(10'd300 + AW'(i), 8'hC3);
    tick();
    cmd_op = 2'd1; cmd_addr = 10'd300; cmd_len = 10'd16; cmd_data = 8'hC3; cmd_valid = 1'b1;
    done_issued++;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    s_we = ram_we; s_rdy = cmd_ready; s_done = cmd_done;
    check("midrst_we", 32'(s_we), 32'd0);
    check("midrst_ready", 32'(s_rdy), 32'd1);
    check("midrst_done", 32'(s_done), 32'd0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("midrst_cell303", 32'(mem[303]), 32'hC3);
    check("midrst_cell304", 32'(mem[304]), 32'h5A);

    nmis = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_vs_model", 32'(nmis), 32'd0);
    check("writes_drained", 32'(rd_tail), 32'(wr_head));
    check("dones_seen", 32'(done_seen), 32'(done_issued));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
